// File: rtl/switching_decoder.sv
// Gate-drive pattern decoder: synchronizes six gate levels, filters them for
// stability and reports the accepted inverter switching vector or a fault.
module switching_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DEAD_MAX      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        t1,
    input  logic        t2,
    input  logic        t3,
    input  logic        t4,
    input  logic        t5,
    input  logic        t6,
    input  logic        fault_clr,
    output logic        s1,
    output logic        s2,
    output logic        s3,
    output logic        s4,
    output logic        s5,
    output logic        s6,
    output logic        s7,
    output logic        s8,
    output logic        vec_valid,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] trans_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DEAD,
        ST_FAULT
    } state_e;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_SHOOT   = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    state_e      state_q, state_d;
    logic [5:0]  sync1_q, sync2_q;
    logic [5:0]  cand_q, cand_d, filt_cand;
    logic [3:0]  cnt_q, cnt_d, filt_cnt;
    logic [7:0]  onehot_q, onehot_d;
    logic [2:0]  last_idx_q, last_idx_d;
    logic [7:0]  dead_cnt_q, dead_cnt_d;
    logic [1:0]  code_q, code_d;
    logic [15:0] trans_q, trans_d, trans_inc;

    logic        pat_shoot, pat_open, pat_valid, pat_dead, accept;
    logic [2:0]  idx;

    // Bit k-1 of the sample is tk; legs are (t1,t4), (t3,t6), (t5,t2).
    assign pat_shoot = (sync2_q[0] & sync2_q[3]) | (sync2_q[2] & sync2_q[5]) |
                       (sync2_q[4] & sync2_q[1]);
    assign pat_open  = (~sync2_q[0] & ~sync2_q[3]) | (~sync2_q[2] & ~sync2_q[5]) |
                       (~sync2_q[4] & ~sync2_q[1]);
    assign pat_dead  = ~pat_shoot & pat_open;
    assign pat_valid = ~pat_shoot & ~pat_open;
    assign idx       = {~sync2_q[4], ~sync2_q[0], ~sync2_q[2]};

    always_comb begin
        if (sync2_q != cand_q) begin
            filt_cand = sync2_q;
            filt_cnt  = 4'd1;
        end else begin
            filt_cand = cand_q;
            filt_cnt  = (cnt_q == '1) ? cnt_q : cnt_q + 4'd1;
        end
    end

    // Acceptance looks at the count this edge will store, so the vector
    // appears on the same edge the counter reaches STABLE_CYCLES.
    assign accept    = pat_valid && (filt_cnt == 4'(STABLE_CYCLES));
    assign trans_inc = (trans_q == '1) ? trans_q : trans_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        cand_d     = filt_cand;
        cnt_d      = filt_cnt;
        onehot_d   = onehot_q;
        last_idx_d = last_idx_q;
        dead_cnt_d = dead_cnt_q;
        code_d     = code_q;
        trans_d    = trans_q;

        case (state_q)
            ST_IDLE: begin
                if (pat_shoot) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_SHOOT;
                end else if (accept) begin
                    state_d    = ST_ACTIVE;
                    onehot_d   = 8'(1) << idx;
                    last_idx_d = idx;
                end
            end
            ST_ACTIVE: begin
                if (pat_shoot) begin
                    state_d  = ST_FAULT;
                    code_d   = CODE_SHOOT;
                    onehot_d = '0;
                end else if (pat_dead) begin
                    state_d    = ST_DEAD;
                    onehot_d   = '0;
                    dead_cnt_d = '0;
                end else if (accept && (idx != last_idx_q)) begin
                    onehot_d   = 8'(1) << idx;
                    last_idx_d = idx;
                    trans_d    = trans_inc;
                end
            end
            ST_DEAD: begin
                if (pat_shoot) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_SHOOT;
                end else if (accept) begin
                    state_d    = ST_ACTIVE;
                    onehot_d   = 8'(1) << idx;
                    last_idx_d = idx;
                    if (idx != last_idx_q) begin
                        trans_d = trans_inc;
                    end
                end else if (dead_cnt_q == 8'(DEAD_MAX - 1)) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_TIMEOUT;
                end else begin
                    dead_cnt_d = dead_cnt_q + 8'd1;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !pat_shoot) begin
                    state_d = ST_IDLE;
                    code_d  = CODE_NONE;
                    cand_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fault_clr && (state_q != ST_FAULT)) begin
            trans_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            onehot_q   <= '0;
            last_idx_q <= '0;
            dead_cnt_q <= '0;
            code_q     <= CODE_NONE;
            trans_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= {t6, t5, t4, t3, t2, t1};
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            onehot_q   <= onehot_d;
            last_idx_q <= last_idx_d;
            dead_cnt_q <= dead_cnt_d;
            code_q     <= code_d;
            trans_q    <= trans_d;
        end
    end

    assign {s8, s7, s6, s5, s4, s3, s2, s1} = onehot_q;
    assign vec_valid   = (state_q == ST_ACTIVE);
    assign fault       = (state_q == ST_FAULT);
    assign fault_code  = code_q;
    assign trans_count = trans_q;

endmodule

// File: tb/tb_switching_decoder.sv
// Directed bench for switching_decoder: expected output words are queued as
// stimulus is driven and compared when the DUT is sampled.
module tb_switching_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic t1 = 1'b0, t2 = 1'b0, t3 = 1'b0, t4 = 1'b0, t5 = 1'b0, t6 = 1'b0;
    logic fault_clr = 1'b0;

    logic        a_s1, a_s2, a_s3, a_s4, a_s5, a_s6, a_s7, a_s8, a_vv, a_f;
    logic [1:0]  a_fc;
    logic [15:0] a_tc;
    logic        b_s1, b_s2, b_s3, b_s4, b_s5, b_s6, b_s7, b_s8, b_vv, b_f;
    logic [1:0]  b_fc;
    logic [15:0] b_tc;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    string       tag_q[$];
    logic [27:0] exp_q[$];
    bit          sel_q[$];

    localparam logic [5:0] V0    = 6'b101010;
    localparam logic [5:0] V1    = 6'b100011;
    localparam logic [5:0] V2    = 6'b001110;
    localparam logic [5:0] DEADA = 6'b001010;
    localparam logic [5:0] DEADB = 6'b000010;
    localparam logic [5:0] SHOOT = 6'b111010;

    always #5 clk = ~clk;

    switching_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6),
        .fault_clr(fault_clr),
        .s1(a_s1), .s2(a_s2), .s3(a_s3), .s4(a_s4),
        .s5(a_s5), .s6(a_s6), .s7(a_s7), .s8(a_s8),
        .vec_valid(a_vv), .fault(a_f), .fault_code(a_fc), .trans_count(a_tc)
    );

    switching_decoder #(.STABLE_CYCLES(1), .DEAD_MAX(16)) dut_fast (
        .clk(clk), .rst_n(rst_n),
        .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6),
        .fault_clr(fault_clr),
        .s1(b_s1), .s2(b_s2), .s3(b_s3), .s4(b_s4),
        .s5(b_s5), .s6(b_s6), .s7(b_s7), .s8(b_s8),
        .vec_valid(b_vv), .fault(b_f), .fault_code(b_fc), .trans_count(b_tc)
    );

    logic [27:0] obs_a, obs_b;
    assign obs_a = {a_s8, a_s7, a_s6, a_s5, a_s4, a_s3, a_s2, a_s1, a_vv, a_f, a_fc, a_tc};
    assign obs_b = {b_s8, b_s7, b_s6, b_s5, b_s4, b_s3, b_s2, b_s1, b_vv, b_f, b_fc, b_tc};

    function automatic logic [7:0] oh_of(input logic [5:0] p);
        case (p)
            6'b101010: return 8'h01;
            6'b100011: return 8'h02;
            6'b001110: return 8'h04;
            6'b000111: return 8'h08;
            6'b111000: return 8'h10;
            6'b110001: return 8'h20;
            6'b011100: return 8'h40;
            6'b010101: return 8'h80;
            default:   return 8'h00;
        endcase
    endfunction

    function automatic logic [27:0] mk(input logic [7:0] oh, input logic v, input logic f,
                                       input logic [1:0] c, input logic [15:0] tc);
        return {oh, v, f, c, tc};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic set_t(input logic [5:0] p);
        {t1, t2, t3, t4, t5, t6} = p;
    endtask

    task automatic expect_out(input string tag, input bit fast, input logic [27:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
        sel_q.push_back(fast);
    endtask

    task automatic check_next();
        string       tag;
        logic [27:0] e, o;
        bit          fast;
        tag  = tag_q.pop_front();
        e    = exp_q.pop_front();
        fast = sel_q.pop_front();
        o    = fast ? obs_b : obs_a;
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed s=%h vv=%b f=%b code=%b tc=%0d, expected s=%h vv=%b f=%b code=%b tc=%0d",
                   tag, o[27:20], o[19], o[18], o[17:16], o[15:0],
                   e[27:20], e[19], e[18], e[17:16], e[15:0]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and first-acceptance latency
        set_t(6'b000000);
        tick(2);
        expect_out("reset_state", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        check_next();
        expect_out("reset_state_fast", 1'b1, mk('0, 0, 0, 2'b00, 16'd0));
        check_next();
        rst_n = 1'b1;
        set_t(V0);
        expect_out("v0_edge5_idle", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        tick(5);
        check_next();
        expect_out("v0_edge6_accept", 1'b0, mk(oh_of(V0), 1, 0, 2'b00, 16'd0));
        tick(1);
        check_next();

        // Open leg for 3 cycles then vector 2
        set_t(DEADA);
        expect_out("dead_entry", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        tick(3);
        check_next();
        set_t(V2);
        expect_out("dead_filtering", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        tick(5);
        check_next();
        expect_out("dead_to_v2", 1'b0, mk(oh_of(V2), 1, 0, 2'b00, 16'd1));
        tick(1);
        check_next();
        fault_clr = 1'b1;
        expect_out("clr_tc_active", 1'b0, mk(oh_of(V2), 1, 0, 2'b00, 16'd0));
        tick(1);
        fault_clr = 1'b0;
        check_next();

        // One-cycle shoot-through, then clear attempt while shooting
        do_reset();
        set_t(V0);
        tick(6);
        set_t(SHOOT);
        tick(1);
        set_t(V0);
        expect_out("shoot_edge2_nofault", 1'b0, mk(oh_of(V0), 1, 0, 2'b00, 16'd0));
        tick(1);
        check_next();
        expect_out("shoot_edge3_fault", 1'b0, mk('0, 0, 1, 2'b01, 16'd0));
        tick(1);
        check_next();
        set_t(SHOOT);
        tick(2);
        fault_clr = 1'b1;
        expect_out("clr_during_shoot", 1'b0, mk('0, 0, 1, 2'b01, 16'd0));
        tick(1);
        fault_clr = 1'b0;
        check_next();

        // Dead-time timeout and recovery
        do_reset();
        set_t(V0);
        tick(6);
        set_t(DEADB);
        expect_out("dead_15_cycles", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        tick(18);
        check_next();
        expect_out("dead_timeout", 1'b0, mk('0, 0, 1, 2'b10, 16'd0));
        tick(1);
        check_next();
        tick(1);
        set_t(V0);
        tick(2);
        fault_clr = 1'b1;
        expect_out("clr_to_idle", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        tick(1);
        fault_clr = 1'b0;
        check_next();
        expect_out("refilter_3", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        tick(3);
        check_next();
        expect_out("refilter_accept", 1'b0, mk(oh_of(V0), 1, 0, 2'b00, 16'd0));
        tick(1);
        check_next();

        // Two-cycle glitch: filtered by default, accepted with STABLE_CYCLES=1
        do_reset();
        set_t(V0);
        tick(6);
        expect_out("glitch_pre_fast", 1'b1, mk(oh_of(V0), 1, 0, 2'b00, 16'd0));
        check_next();
        set_t(V1);
        tick(2);
        set_t(V0);
        expect_out("glitch_e3", 1'b0, mk(oh_of(V0), 1, 0, 2'b00, 16'd0));
        expect_out("glitch_e3_fast", 1'b1, mk(oh_of(V1), 1, 0, 2'b00, 16'd1));
        tick(1);
        check_next();
        check_next();
        expect_out("glitch_e5", 1'b0, mk(oh_of(V0), 1, 0, 2'b00, 16'd0));
        expect_out("glitch_e5_fast", 1'b1, mk(oh_of(V0), 1, 0, 2'b00, 16'd2));
        tick(2);
        check_next();
        check_next();
        expect_out("glitch_e8", 1'b0, mk(oh_of(V0), 1, 0, 2'b00, 16'd0));
        tick(3);
        check_next();

        // Build trans_count=5, then asynchronous reset mid-cycle
        do_reset();
        set_t(V0);
        tick(6);
        for (int i = 0; i < 5; i++) begin
            set_t((i % 2 == 0) ? V1 : V0);
            tick(6);
        end
        expect_out("tc5", 1'b0, mk(oh_of(V1), 1, 0, 2'b00, 16'd5));
        expect_out("tc5_fast", 1'b1, mk(oh_of(V1), 1, 0, 2'b00, 16'd5));
        check_next();
        check_next();
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        expect_out("async_reset_fast", 1'b1, mk('0, 0, 0, 2'b00, 16'd0));
        check_next();
        check_next();
        tick(1);
        rst_n = 1'b1;
        expect_out("post_reset_tc0", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        check_next();
        expect_out("post_reset_e5", 1'b0, mk('0, 0, 0, 2'b00, 16'd0));
        tick(5);
        check_next();
        expect_out("post_reset_e6", 1'b0, mk(oh_of(V1), 1, 0, 2'b00, 16'd0));
        tick(1);
        check_next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
